// File: rtl/sync_word_handshake_if.sv
// Handshake bundle for sync_word_handshake: source write side plus destination word output.
`timescale 1ns/100ps
interface sync_word_handshake_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sEN;
  logic [WIDTH-1:0] sD_IN;
  logic             sRDY;
  logic             sOVR;
  logic [WIDTH-1:0] dD_OUT;
  logic             dVALID;

  modport master (
    output sEN, sD_IN,
    input  sRDY, sOVR, dD_OUT, dVALID
  );

  modport slave (
    input  sEN, sD_IN,
    output sRDY, sOVR, dD_OUT, dVALID
  );
endinterface

// File: rtl/sync_word_handshake.sv
// Multi-bit CDC for control/status words: toggle req/ack handshake carries one coherent
// source word into the destination domain; flow control via sRDY, sticky overrun via sOVR.
`timescale 1ns/100ps
module sync_word_handshake #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STAGES    = 2,
  parameter bit               NEG_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] init      = '0
) (
  input  logic                 sCLK,
  input  logic                 sRST_N,
  input  logic                 dCLK,
  sync_word_handshake_if.slave hs
);

  logic [WIDTH-1:0]  sData_q, sData_d;
  logic              sReqTog_q, sReqTog_d;
  logic              sOvr_q, sOvr_d;
  logic [STAGES-1:0] sAckSync_q;
  logic              sRdy;

  logic              dReqFirst_q;
  logic [STAGES-2:0] dReqTail_q;
  logic [STAGES-1:0] dReqChain;
  logic              dAckTog_q;
  logic [WIDTH-1:0]  dData_q;
  logic              dValid_q;
  logic              dNew;

  // Source is idle once the returned ack matches the outstanding req.
  assign sRdy = (sAckSync_q[STAGES-1] == sReqTog_q);

  always_comb begin
    sData_d   = sData_q;
    sReqTog_d = sReqTog_q;
    sOvr_d    = sOvr_q;
    if (hs.sEN) begin
      if (sRdy) begin
        sData_d   = hs.sD_IN;
        sReqTog_d = ~sReqTog_q;
      end else begin
        sOvr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sCLK or negedge sRST_N) begin
    if (!sRST_N) begin
      sData_q    <= init;
      sReqTog_q  <= 1'b0;
      sOvr_q     <= 1'b0;
      sAckSync_q <= '0;
    end else begin
      sData_q    <= sData_d;
      sReqTog_q  <= sReqTog_d;
      sOvr_q     <= sOvr_d;
      sAckSync_q <= {sAckSync_q[STAGES-2:0], dAckTog_q};
    end
  end

  // First req synchroniser flop optionally samples on the falling edge to trim latency.
  if (NEG_FIRST) begin : g_first_neg
    always_ff @(negedge dCLK or negedge sRST_N) begin
      if (!sRST_N) dReqFirst_q <= 1'b0;
      else         dReqFirst_q <= sReqTog_q;
    end
  end else begin : g_first_pos
    always_ff @(posedge dCLK or negedge sRST_N) begin
      if (!sRST_N) dReqFirst_q <= 1'b0;
      else         dReqFirst_q <= sReqTog_q;
    end
  end

  assign dReqChain = {dReqTail_q, dReqFirst_q};
  assign dNew      = (dReqChain[STAGES-1] != dAckTog_q);

  // sData_q is frozen while req and ack differ, so the wide capture below is coherent.
  always_ff @(posedge dCLK or negedge sRST_N) begin
    if (!sRST_N) begin
      dReqTail_q <= '0;
      dAckTog_q  <= 1'b0;
      dData_q    <= init;
      dValid_q   <= 1'b0;
    end else begin
      dReqTail_q <= dReqChain[STAGES-2:0];
      dValid_q   <= dNew;
      if (dNew) begin
        dData_q   <= sData_q;
        dAckTog_q <= ~dAckTog_q;
      end
    end
  end

  assign hs.sRDY   = sRdy;
  assign hs.sOVR   = sOvr_q;
  assign hs.dD_OUT = dData_q;
  assign hs.dVALID = dValid_q;

endmodule
